// File: rtl/rtc_bus_scheduler.sv
// RTC multiplexed bus scheduler: fixed-priority arbitration of three sequencers
// and timed address/gap/data/recovery cycles on the RTC parallel bus.
module rtc_bus_scheduler #(
  parameter int T_ADDR = 2,
  parameter int T_GAP  = 1,
  parameter int T_DATA = 3,
  parameter int T_REC  = 2,
  parameter int CNT_W  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inic_listo,
  input  logic [2:0]  req,
  input  logic [2:0]  rnw,
  input  logic [23:0] dir_in,
  input  logic [23:0] dato_in,
  output logic [2:0]  grant,
  output logic [2:0]  ack,
  output logic        busy,
  output logic [7:0]  rdata,
  input  logic [7:0]  bus_in,
  output logic [7:0]  bus_out,
  output logic        bus_oe,
  output logic        a_d,
  output logic        cs,
  output logic        rd,
  output logic        wr
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADDR = 3'd1;
  localparam logic [2:0] GAP  = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] REC  = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(T_ADDR - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(T_DATA - 1);
  localparam logic [CNT_W-1:0] REC_LAST  = CNT_W'(T_REC - 1);

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       owner, owner_nxt;
  logic             own_rnw, rnw_nxt;
  logic [7:0]       addr_q, addr_nxt;
  logic [7:0]       wdata_q, wdata_nxt;

  logic [2:0] eff_req;
  logic [1:0] win_idx;
  logic       win_rnw;
  logic [7:0] win_addr;
  logic [7:0] win_data;
  logic [2:0] owner_oh;
  logic       drive_wdata;

  // Sequencers 1 and 2 stay masked until initialization reports done.
  assign eff_req = req & {inic_listo, inic_listo, 1'b1};

  always_comb begin
    win_idx  = 2'd2;
    win_rnw  = rnw[2];
    win_addr = dir_in[23:16];
    win_data = dato_in[23:16];
    if (eff_req[0]) begin
      win_idx  = 2'd0;
      win_rnw  = rnw[0];
      win_addr = dir_in[7:0];
      win_data = dato_in[7:0];
    end else if (eff_req[1]) begin
      win_idx  = 2'd1;
      win_rnw  = rnw[1];
      win_addr = dir_in[15:8];
      win_data = dato_in[15:8];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    owner_nxt = owner;
    rnw_nxt   = own_rnw;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (|eff_req) begin
          state_nxt = ADDR;
          owner_nxt = win_idx;
          rnw_nxt   = win_rnw;
          addr_nxt  = win_addr;
          wdata_nxt = win_data;
        end
      end
      ADDR: if (cnt == ADDR_LAST) begin state_nxt = GAP;  cnt_nxt = '0; end
      GAP:  if (cnt == GAP_LAST)  begin state_nxt = DATA; cnt_nxt = '0; end
      DATA: if (cnt == DATA_LAST) begin state_nxt = REC;  cnt_nxt = '0; end
      REC:  if (cnt == REC_LAST)  begin state_nxt = DONE; cnt_nxt = '0; end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign owner_oh    = 3'b001 << owner_nxt;
  assign drive_wdata = !rnw_nxt && (state_nxt == GAP || state_nxt == DATA);

  // Bus outputs are decoded from the next state so every pin is a flop output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      owner   <= 2'd0;
      own_rnw <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      grant   <= 3'b000;
      ack     <= 3'b000;
      busy    <= 1'b0;
      rdata   <= 8'h00;
      bus_out <= 8'h00;
      bus_oe  <= 1'b0;
      a_d     <= 1'b1;
      cs      <= 1'b1;
      rd      <= 1'b1;
      wr      <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      owner   <= owner_nxt;
      own_rnw <= rnw_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      grant   <= (state_nxt == IDLE) ? 3'b000 : owner_oh;
      ack     <= (state_nxt == DONE) ? owner_oh : 3'b000;
      busy    <= (state_nxt != IDLE);
      cs      <= !(state_nxt == ADDR || state_nxt == DATA);
      a_d     <= (state_nxt != ADDR);
      rd      <= !(state_nxt == DATA && rnw_nxt);
      wr      <= !(state_nxt == ADDR || (state_nxt == DATA && !rnw_nxt));
      bus_oe  <= (state_nxt == ADDR) || drive_wdata;
      bus_out <= (state_nxt == ADDR) ? addr_nxt : (drive_wdata ? wdata_nxt : 8'h00);
      if (state == DATA && state_nxt == REC && own_rnw)
        rdata <= bus_in;
    end
  end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Bench for rtc_bus_scheduler: table of transactions, per-cycle bus trace
// comparison and an ack/rdata scoreboard.
module tb_rtc_bus_scheduler;

  typedef struct {
    int         idx;
    logic       rnw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] bin;
  } txn_t;

  typedef struct {
    logic [2:0] ack;
    logic       is_read;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        inic_listo = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [2:0]  rnw = 3'b000;
  logic [23:0] dir_in = '0;
  logic [23:0] dato_in = '0;
  logic [7:0]  bus_in = 8'h00;
  logic [2:0]  grant, ack;
  logic        busy, bus_oe, a_d, cs, rd, wr;
  logic [7:0]  rdata, bus_out;

  int   checks = 0;
  int   errors = 0;
  logic [7:0] model_rdata = 8'h00;
  exp_t exp_q[$];
  txn_t vec[8];

  rtc_bus_scheduler dut (
    .clk(clk), .reset(reset), .inic_listo(inic_listo), .req(req), .rnw(rnw),
    .dir_in(dir_in), .dato_in(dato_in), .grant(grant), .ack(ack), .busy(busy),
    .rdata(rdata), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .a_d(a_d), .cs(cs), .rd(rd), .wr(wr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] cur_vec();
    return {cs, a_d, rd, wr, bus_oe, (bus_oe ? bus_out : 8'h00), grant, ack, busy};
  endfunction

  // Expected bus/handshake pins k cycles after the granting edge (k=9 is the idle cycle).
  function automatic logic [19:0] exp_vec(input txn_t t, input int k);
    logic csx, adx, rdx, wrx, oex, b;
    logic [7:0] bo;
    logic [2:0] g, a;
    csx = 1'b1; adx = 1'b1; rdx = 1'b1; wrx = 1'b1; oex = 1'b0; b = 1'b0;
    bo = 8'h00; g = 3'b000; a = 3'b000;
    if (k <= 8) begin
      g = 3'b001 << t.idx;
      b = 1'b1;
    end
    if (k <= 1) begin
      csx = 1'b0; adx = 1'b0; wrx = 1'b0; oex = 1'b1; bo = t.addr;
    end else if (k == 2) begin
      oex = !t.rnw; bo = t.rnw ? 8'h00 : t.wdata;
    end else if (k <= 5) begin
      csx = 1'b0; rdx = !t.rnw; wrx = t.rnw; oex = !t.rnw; bo = t.rnw ? 8'h00 : t.wdata;
    end else if (k == 8) begin
      a = g;
    end
    return {csx, adx, rdx, wrx, oex, bo, g, a, b};
  endfunction

  task automatic apply_stimulus(input txn_t t);
    exp_t e;
    rnw[t.idx] = t.rnw;
    dir_in[t.idx*8 +: 8] = t.addr;
    dato_in[t.idx*8 +: 8] = t.wdata;
    req[t.idx] = 1'b1;
    e.ack = 3'b001 << t.idx;
    e.is_read = t.rnw;
    e.data = t.bin;
    exp_q.push_back(e);
  endtask

  // Waits for the grant, then compares every cycle through the following idle cycle.
  task automatic serve(input txn_t t, input int exp_wait);
    int waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (grant == 3'b000 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (grant == 3'b000) begin
      check_output("grant_timeout", {29'b0, grant}, 32'(3'b001 << t.idx));
      return;
    end
    check_output($sformatf("arb_wait_i%0d", t.idx), waited, exp_wait);
    bus_in = t.bin;
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) @(negedge clk);
      check_output($sformatf("trace_i%0d_k%0d", t.idx, k), {12'b0, cur_vec()}, {12'b0, exp_vec(t, k)});
      if (k == 8) begin
        if (exp_q.size() == 0) begin
          check_output("scoreboard_empty", {29'b0, ack}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_output($sformatf("ack_i%0d", t.idx), {29'b0, ack}, {29'b0, e.ack});
          if (e.is_read) model_rdata = e.data;
          check_output($sformatf("rdata_i%0d", t.idx), {24'b0, rdata}, {24'b0, model_rdata});
        end
        req[t.idx] = 1'b0;
      end
    end
  endtask

  initial begin
    int waited;
    vec[0] = '{idx: 0, rnw: 1'b0, addr: 8'h02, wdata: 8'h10, bin: 8'h00};
    vec[1] = '{idx: 2, rnw: 1'b1, addr: 8'h21, wdata: 8'h00, bin: 8'h59};
    vec[2] = '{idx: 1, rnw: 1'b0, addr: 8'h40, wdata: 8'h77, bin: 8'hEE};
    vec[3] = '{idx: 0, rnw: 1'b1, addr: 8'h05, wdata: 8'h00, bin: 8'hC3};
    vec[4] = '{idx: 1, rnw: 1'b1, addr: 8'h11, wdata: 8'h00, bin: 8'h3C};
    vec[5] = '{idx: 2, rnw: 1'b0, addr: 8'h7F, wdata: 8'h01, bin: 8'h00};
    vec[6] = '{idx: 1, rnw: 1'b0, addr: 8'h33, wdata: 8'hA5, bin: 8'h00};
    vec[7] = '{idx: 0, rnw: 1'b0, addr: 8'h4E, wdata: 8'h9D, bin: 8'h00};

    repeat (3) @(negedge clk);
    reset = 1'b1;
    inic_listo = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_output($sformatf("idle_%0d", i), {12'b0, cur_vec()}, {12'b0, exp_vec(vec[0], 9)});
    end
    check_output("rdata_reset", {24'b0, rdata}, 32'd0);

    // Single transactions from the table, one after another.
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vec[i]);
      serve(vec[i], 0);
    end

    // Requesters 1 and 2 are masked until initialization completes.
    inic_listo = 1'b0;
    apply_stimulus(vec[6]);
    apply_stimulus(vec[5]);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output($sformatf("masked_%0d", i), {28'b0, grant, busy}, 32'd0);
    end
    inic_listo = 1'b1;
    serve(vec[6], 0);
    serve(vec[5], 0);

    // All three at once, raised together with inic_listo.
    inic_listo = 1'b0;
    @(negedge clk);
    inic_listo = 1'b1;
    apply_stimulus(vec[3]);
    apply_stimulus(vec[4]);
    apply_stimulus(vec[1]);
    serve(vec[3], 0);
    serve(vec[4], 0);
    serve(vec[1], 0);

    // Reset pulse during the data phase of a write; req stays held.
    apply_stimulus(vec[7]);
    waited = 0;
    @(negedge clk);
    while (grant == 3'b000 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    check_output("pre_reset_data", {12'b0, cur_vec()}, {12'b0, exp_vec(vec[7], 3)});
    #2 reset = 1'b0;
    #1 check_output("async_reset", {12'b0, cur_vec()}, {12'b0, exp_vec(vec[7], 9)});
    model_rdata = 8'h00;
    check_output("async_reset_rdata", {24'b0, rdata}, 32'd0);
    repeat (2) @(negedge clk);
    check_output("held_reset", {12'b0, cur_vec()}, {12'b0, exp_vec(vec[7], 9)});
    reset = 1'b1;
    serve(vec[7], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_bus_scheduler.md
Name: rtc_bus_scheduler

Overview:
- Owns the RTC multiplexed parallel bus (a_d, cs, rd, wr, 8-bit address/data).
- Arbitrates single-byte transactions from three sequencers: initialization (index 0), write/programming (index 1) and periodic time read (index 2).
- Runs each granted transaction as a timed address-phase / data-phase cycle and returns an ack, plus read data for reads.
- Sits between the sequencers and the RTC pad/tristate logic.

Parameters:
- T_ADDR, 2, cycles in address phase (min 1)
- T_GAP, 1, cycles between address and data phases (min 1)
- T_DATA, 3, cycles in data phase; rd/wr strobe width (min 1)
- T_REC, 2, recovery cycles after data phase (min 1)
- CNT_W, 4, phase counter width; every T_* value must be at most 2^CNT_W-1

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- inic_listo  in  1  1 = initialization finished; requesters 1 and 2 are masked while it is 0
- req  in  3  per-requester request, level; must be held until the matching ack
- rnw  in  3  per-requester direction, 1 = read, 0 = write
- dir_in  in  24  packed 8-bit RTC addresses; requester i uses bits [8i+7:8i]
- dato_in  in  24  packed 8-bit write data, same packing as dir_in
- grant  out  3  one-hot owner of the current transaction; 0 when idle
- ack  out  3  one-cycle completion pulse to the owner
- busy  out  1  1 in any state other than IDLE
- rdata  out  8  last byte read from the RTC
- bus_in  in  8  RTC bus input from the pads
- bus_out  out  8  RTC bus drive value
- bus_oe  out  1  1 = drive bus_out onto the pads
- a_d  out  1  0 = address phase, 1 = data/idle
- cs  out  1  chip select, active low
- rd  out  1  read strobe, active low
- wr  out  1  write strobe, active low

Behaviour:
- Reset values (asynchronous, taken immediately when reset=0, including mid-transaction):
  - state=IDLE
  - a_d=cs=rd=wr=1
  - bus_oe=0, bus_out=0
  - grant=0, ack=0, busy=0, rdata=0
  - counter=0
- All outputs are registered.
- Arbitration happens only in IDLE, at a clock edge. Fixed priority 0 > 1 > 2.
  - Effective request = req & {inic_listo, inic_listo, 1}.
  - The winner's index, rnw, address and data are latched at that edge, and grant is set one-hot.
  - Later changes to req, dir_in or dato_in have no effect until DONE.
- States and per-state outputs:
  - IDLE: bus lines idle.
  - ADDR (T_ADDR cycles): cs=0, a_d=0, wr=0, bus_oe=1, bus_out=address.
  - GAP (T_GAP cycles): cs=1, a_d=1, rd=wr=1; bus_oe=0 for reads, 1 with bus_out=wdata for writes (data setup).
  - DATA (T_DATA cycles): cs=0, a_d=1.
    - Read: rd=0, bus_oe=0; rdata is captured from bus_in on the edge that leaves DATA.
    - Write: wr=0, bus_oe=1, bus_out=wdata.
  - REC (T_REC cycles): all strobes 1, bus_oe=0.
  - DONE (1 cycle): ack[owner]=1; then IDLE, where grant clears.
- Phase counter: loads at state entry; the state exits when the counter reaches T_x-1.
- Latency: ack rises T_ADDR+T_GAP+T_DATA+T_REC clock edges after the granting edge (8 with defaults).
- Back-to-back transactions: DONE always returns to IDLE, so there is a minimum one IDLE cycle between transactions. The requester drops req on the edge where it sees ack, and that IDLE cycle prevents the stale req from being re-granted.
- Pending lower-priority requests wait; no starvation protection. The initialization requester is trusted to finish.
- A req deasserted mid-transaction does not abort it; ack is still issued.
- rdata holds its value across writes and idle periods.
- A requester whose req rises while it already owns the bus is served only after DONE→IDLE.
- inic_listo falling mid-transaction does not abort the transaction; it affects only later arbitration.

Test Plan:
- After reset release with no req: a_d=cs=rd=wr=1, bus_oe=0, grant=0, busy=0 held for 20 cycles.
- req=3'b001, rnw[0]=0, dir_in[7:0]=8'h02, dato_in[7:0]=8'h10 → grant=001; cs/a_d/wr low with bus_out=8'h02 for 2 cycles; 1 gap cycle; wr=0 with bus_out=8'h10 for 3 cycles; 2 recovery cycles; ack=001 for one cycle, 8 edges after the grant; busy=0 on the next cycle.
- inic_listo=0, req=3'b110 → no grant for 10 cycles. Raise inic_listo → grant=010 first; after its ack and req[1] drop, grant=100.
- Read by requester 2 at address 8'h21, with bus_in=8'h59 during DATA → rd=0 for 3 cycles, bus_oe=0 throughout the data phase, rdata=8'h59 from the edge leaving DATA and held through a subsequent write.
- req=3'b111 raised simultaneously with inic_listo=1 → service order 0, 1, 2 (each dropping req on its ack), exactly one IDLE cycle between transactions, each ack one-hot to the correct index.
- reset pulsed low during DATA of a write → strobes go 1 and bus_oe goes 0 asynchronously (before the next clock edge), no ack issued, grant=0. After release with req still held, the transaction restarts from ADDR.
